wblock_sched: RTL and testbench

Frame-level controller placed after the per-line column-block summer in the camera capture path. It accumulates per-segment sums across ROW_BLOCK_HEIGHT lines into one accumulator per column block, giving one value per tile. At each row-block boundary it swaps ping-pong banks. It then drains the completed bank as framed 7-byte packets over a valid/ready byte stream to the serial/host side.

---
 rtl/wblock_sched_if.sv | 25 ++
 rtl/wblock_sched.sv | 167 ++++++++++++++++
 tb/tb_wblock_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wblock_sched_if.sv
// Capture-side sum stream in, framed tile packets out; master drives sums and ready, slave is the scheduler.
// Byte stream is registered valid/ready; the sum side has no backpressure.
interface wblock_sched_if #(
  parameter int SUM_IN_W = 16
);
  logic                vsync;
  logic                href;
  logic                sum_valid;
  logic [SUM_IN_W-1:0] sum_in;
  logic                dout_valid;
  logic [7:0]          dout;
  logic                dout_ready;
  logic                frame_done;
  logic                overrun;

  modport master (
    output vsync, href, sum_valid, sum_in, dout_ready,
    input  dout_valid, dout, frame_done, overrun
  );

  modport slave (
    input  vsync, href, sum_valid, sum_in, dout_ready,
    output dout_valid, dout, frame_done, overrun
  );
endinterface

// File: rtl/wblock_sched.sv
// Per-tile accumulator with ping-pong banks; drains a finished row block as 7-byte packets.
// First byte valid one cycle after the row-block line end; bytes hold while dout_ready is low.
module wblock_sched #(
  parameter int COL_BLOCKS       = 4,
  parameter int ROW_BLOCKS       = 4,
  parameter int ROW_BLOCK_HEIGHT = 3,
  parameter int SUM_IN_W         = 16,
  parameter int ACC_W            = 24
) (
  input  logic         pclk,
  input  logic         rst_n,
  wblock_sched_if.slave bus
);
  localparam int CW = $clog2(COL_BLOCKS + 1);
  localparam int EW = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;
  localparam int LW = $clog2(ROW_BLOCK_HEIGHT + 1);
  localparam int RW = $clog2(ROW_BLOCKS + 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(COL_BLOCKS);
  localparam logic [EW-1:0] ENT_LAST  = EW'(COL_BLOCKS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(ROW_BLOCK_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(ROW_BLOCKS);
  localparam logic [7:0]    ROW_LAST  = 8'(ROW_BLOCKS - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state, state_nx;
  logic             href_d;
  logic [CW-1:0]    col_idx;
  logic [LW-1:0]    line_cnt;
  logic [RW-1:0]    row_blk;
  logic             active;
  logic [7:0]       drain_row;
  logic             overrun_q;
  logic [ACC_W-1:0] acc [2][COL_BLOCKS];
  logic [ACC_W:0]   acc_sum;
  logic [EW-1:0]    ent, ent_nx;
  logic [2:0]       bidx, bidx_nx;
  logic [7:0]       dout_q, dout_nx;
  logic             vld_q, vld_nx, fd_q, fd_nx;
  logic [ACC_W-1:0] rd_val;
  logic             line_end, frame_open, col_ok, do_acc, blk_end, busy, swap, last_xfer;

  assign line_end   = href_d & ~bus.href;
  assign frame_open = row_blk < ROW_MAX;
  assign col_ok     = col_idx < COL_MAX;
  assign do_acc     = bus.sum_valid & ~bus.vsync & frame_open & col_ok;
  assign blk_end    = line_end & ~bus.vsync & frame_open & (line_cnt == LINE_LAST);
  assign busy       = (state != IDLE);
  assign swap       = blk_end & ~busy;
  assign last_xfer  = (ent == ENT_LAST) && (bidx == 3'd6);
  assign acc_sum    = {1'b0, acc[active][col_idx[EW-1:0]]} + (ACC_W+1)'(bus.sum_in);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_d    <= 1'b0;
      col_idx   <= '0;
      line_cnt  <= '0;
      row_blk   <= '0;
      active    <= 1'b0;
      drain_row <= '0;
      overrun_q <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < COL_BLOCKS; c++)
          acc[b][c] <= '0;
    end else begin
      href_d <= bus.href;
      if (bus.vsync) begin
        col_idx  <= '0;
        line_cnt <= '0;
        row_blk  <= '0;
        for (int c = 0; c < COL_BLOCKS; c++) acc[active][c] <= '0;
      end else begin
        if (line_end)
          col_idx <= '0;
        else if (bus.sum_valid && col_ok)
          col_idx <= col_idx + 1'b1;
        if (do_acc)
          acc[active][col_idx[EW-1:0]] <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        if (line_end && frame_open)
          line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
        // The clears below override any same-cycle accumulate into the bank being reset.
        if (blk_end) begin
          row_blk <= row_blk + 1'b1;
          if (busy) begin
            overrun_q <= 1'b1;
            for (int c = 0; c < COL_BLOCKS; c++) acc[active][c] <= '0;
          end else begin
            active    <= ~active;
            drain_row <= 8'(row_blk);
            for (int c = 0; c < COL_BLOCKS; c++) acc[~active][c] <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ent    <= '0;
      bidx   <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      ent    <= ent_nx;
      bidx   <= bidx_nx;
      dout_q <= dout_nx;
      vld_q  <= vld_nx;
      fd_q   <= fd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ent_nx   = ent;
    bidx_nx  = bidx;
    dout_nx  = dout_q;
    vld_nx   = vld_q;
    fd_nx    = 1'b0;
    rd_val   = '0;
    case (state)
      IDLE: begin
        if (swap) begin
          state_nx = SEND;
          ent_nx   = '0;
          bidx_nx  = '0;
          vld_nx   = 1'b1;
          dout_nx  = 8'h55;
        end
      end
      SEND: begin
        if (bus.dout_ready) begin
          if (last_xfer) begin
            state_nx = IDLE;
            vld_nx   = 1'b0;
            fd_nx    = (drain_row == ROW_LAST);
          end else begin
            if (bidx == 3'd6) begin
              ent_nx  = ent + 1'b1;
              bidx_nx = '0;
            end else begin
              bidx_nx = bidx + 1'b1;
            end
            // The drain bank is the one not being accumulated into.
            rd_val = acc[~active][ent_nx];
            case (bidx_nx)
              3'd0:    dout_nx = 8'h55;
              3'd1:    dout_nx = 8'h66;
              3'd2:    dout_nx = drain_row;
              3'd3:    dout_nx = 8'(ent_nx);
              3'd4:    dout_nx = rd_val[23:16];
              3'd5:    dout_nx = rd_val[15:8];
              default: dout_nx = rd_val[7:0];
            endcase
          end
        end
      end
    endcase
  end

  assign bus.dout_valid = vld_q;
  assign bus.dout       = dout_q;
  assign bus.frame_done = fd_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_wblock_sched.sv
// Randomised and directed bench for wblock_sched against a tile-sum packet model.
module tb_wblock_sched;
  localparam int CB = 4;
  localparam int RB = 4;
  localparam int H  = 3;
  localparam int HS = 300;

  logic pclk = 1'b0;
  logic rst_n;
  always #5 pclk = ~pclk;

  wblock_sched_if #(.SUM_IN_W(16)) mif ();
  wblock_sched_if #(.SUM_IN_W(16)) sif ();

  wblock_sched #(.COL_BLOCKS(CB), .ROW_BLOCKS(RB), .ROW_BLOCK_HEIGHT(H),
                 .SUM_IN_W(16), .ACC_W(24))
    dut (.pclk(pclk), .rst_n(rst_n), .bus(mif));

  wblock_sched #(.COL_BLOCKS(CB), .ROW_BLOCKS(RB), .ROW_BLOCK_HEIGHT(HS),
                 .SUM_IN_W(16), .ACC_W(24))
    dut_sat (.pclk(pclk), .rst_n(rst_n), .bus(sif));

  assign sif.vsync      = mif.vsync;
  assign sif.href       = mif.href;
  assign sif.sum_valid  = mif.sum_valid;
  assign sif.sum_in     = mif.sum_in;
  assign sif.dout_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per-tile integer sums, pending byte queue ({last-of-frame flag, byte}).
  longint     macc [CB];
  logic [8:0] expq [$];
  logic [7:0] got [$];
  logic [7:0] sat_got [$];
  int m_col = 0, m_lines = 0, m_row = 0;
  bit m_href = 0, exp_ov = 0, exp_fd = 0;
  int fd_count = 0;

  task automatic push_row(input int r);
    longint v;
    for (int e = 0; e < CB; e++) begin
      v = (macc[e] > 64'hFFFFFF) ? 64'hFFFFFF : macc[e];
      expq.push_back({1'b0, 8'h55});
      expq.push_back({1'b0, 8'h66});
      expq.push_back({1'b0, 8'(r)});
      expq.push_back({1'b0, 8'(e)});
      expq.push_back({1'b0, 8'(v >> 16)});
      expq.push_back({1'b0, 8'(v >> 8)});
      expq.push_back({(r == RB-1) && (e == CB-1), 8'(v)});
    end
  endtask

  initial forever begin
    @(posedge pclk or negedge rst_n);
    if (!rst_n) begin
      expq.delete();
      m_col = 0; m_lines = 0; m_row = 0; m_href = 0; exp_ov = 0; exp_fd = 0;
      for (int c = 0; c < CB; c++) macc[c] = 0;
    end else begin
      bit busy, le;
      logic [8:0] f;
      busy   = (expq.size() != 0);
      exp_fd = 0;
      if (mif.dout_valid === 1'b1 && mif.dout_ready && expq.size() != 0) begin
        f = expq.pop_front();
        got.push_back(mif.dout);
        if (f[8]) exp_fd = 1;
      end
      le     = m_href && !mif.href;
      m_href = mif.href;
      if (mif.vsync) begin
        m_col = 0; m_lines = 0; m_row = 0;
        for (int c = 0; c < CB; c++) macc[c] = 0;
      end else begin
        if (mif.sum_valid && m_row < RB && m_col < CB) macc[m_col] += longint'(mif.sum_in);
        if (mif.sum_valid) m_col++;
        if (le) begin
          m_col = 0;
          if (m_row < RB) begin
            m_lines++;
            if (m_lines == H) begin
              m_lines = 0;
              if (busy) exp_ov = 1;
              else push_row(m_row);
              m_row++;
              for (int c = 0; c < CB; c++) macc[c] = 0;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    @(posedge pclk);
    forever begin
      @(negedge pclk);
      check("dout_valid", mif.dout_valid, expq.size() != 0);
      if (expq.size() != 0) check("dout", mif.dout, expq[0][7:0]);
      check("overrun", mif.overrun, exp_ov);
      check("frame_done", mif.frame_done, exp_fd);
      if (mif.frame_done === 1'b1) fd_count++;
    end
  end

  initial forever begin
    @(posedge pclk);
    if (rst_n && sif.dout_valid === 1'b1) sat_got.push_back(sif.dout);
  end

  int rmode = 0;
  int rcnt  = 0;
  initial begin
    mif.dout_ready = 1'b0;
    forever begin
      @(posedge pclk); #1;
      case (rmode)
        0: mif.dout_ready = 1'b1;
        1: mif.dout_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
        2: mif.dout_ready = 1'b0;
        default: mif.dout_ready = 1'($urandom_range(0, 1));
      endcase
      rcnt++;
    end
  end

  logic [15:0] lv [6];

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic do_line(input int np, input int endp, input int gmax);
    mif.href = 1'b1; tick();
    for (int c = 0; c < np; c++) begin
      if (c == np-1 && endp != 0) mif.href = 1'b0;
      mif.sum_valid = 1'b1; mif.sum_in = lv[c]; tick();
      mif.sum_valid = 1'b0;
      if (gmax > 0) repeat ($urandom_range(0, gmax)) tick();
    end
    mif.href = 1'b0; tick(); tick();
  endtask

  task automatic pulse_vsync();
    mif.vsync = 1'b1; repeat (3) tick();
    mif.vsync = 1'b0; tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; repeat (2) tick();
    rst_n = 1'b1; tick();
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((expq.size() != 0 || mif.dout_valid !== 1'b0) && n < maxc) begin
      tick(); n++;
    end
    check("drain_timeout", n < maxc, 1);
  endtask

  function automatic logic [7:0] tile_byte(input int i);
    int e = i / 7;
    case (i % 7)
      0: return 8'h55;
      1: return 8'h66;
      3: return 8'(e);
      6: return 8'((e + 1) * 8'h30);
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    rst_n = 1'b1;
    mif.vsync = 0; mif.href = 0; mif.sum_valid = 0; mif.sum_in = 0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_dout_valid", mif.dout_valid, 0);
    check("rst_dout", mif.dout, 0);
    check("rst_overrun", mif.overrun, 0);
    check("rst_frame_done", mif.frame_done, 0);
    rst_n = 1'b1; tick();

    // Basic tile
    rmode = 0;
    lv[0] = 16'h10; lv[1] = 16'h20; lv[2] = 16'h30; lv[3] = 16'h40;
    got.delete();
    repeat (3) do_line(CB, 0, 0);
    wait_idle(200);
    check("t1_count", got.size(), 28);
    for (int i = 0; i < 28; i++) check("t1_byte", got[i], tile_byte(i));

    // Backpressure
    pulse_vsync();
    got.delete(); rmode = 1;
    repeat (3) do_line(CB, 0, 0);
    wait_idle(400);
    check("t2_count", got.size(), 28);
    for (int i = 0; i < 28; i++) check("t2_byte", got[i], tile_byte(i));

    // Saturation on the tall-block instance
    rmode = 0;
    pulse_vsync();
    sat_got.delete();
    for (int c = 0; c < CB; c++) lv[c] = 16'hFFFF;
    repeat (HS) do_line(CB, 0, 0);
    for (int n = 0; n < 200 && sat_got.size() < 28; n++) tick();
    check("sat_count", sat_got.size() >= 28, 1);
    for (int e = 0; e < CB; e++) begin
      check("sat_hdr", sat_got[7*e], 8'h55);
      check("sat_ent", sat_got[7*e+3], e);
      check("sat_hi", sat_got[7*e+4], 8'hFF);
      check("sat_mid", sat_got[7*e+5], 8'hFF);
      check("sat_lo", sat_got[7*e+6], 8'hFF);
    end
    wait_idle(200);

    // Overrun
    do_reset();
    rmode = 2;
    for (int c = 0; c < CB; c++) lv[c] = 16'($urandom);
    repeat (2*H) do_line(CB, 0, 1);
    tick();
    check("ovr_set", mif.overrun, 1);
    got.delete(); rmode = 0;
    wait_idle(200);
    check("ovr_count", got.size(), 28);
    check("ovr_row", got[2], 0);

    // Async reset mid drain
    rmode = 2;
    repeat (H) do_line(CB, 0, 0);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", mif.dout_valid, 0);
    check("arst_overrun", mif.overrun, 0);
    tick(); rst_n = 1'b1; tick();

    // Frame end
    rmode = 0; fd_count = 0; got.delete();
    for (int r = 0; r < RB; r++) begin
      for (int c = 0; c < CB; c++) lv[c] = 16'($urandom);
      repeat (H) do_line(CB, $urandom_range(0, 1), 1);
      wait_idle(200);
    end
    repeat (H) do_line(CB, 0, 0);
    repeat (40) tick();
    check("fe_frame_done", fd_count, 1);
    check("fe_count", got.size(), RB*28);
    for (int k = 0; k < RB; k++) check("fe_row", got[2 + 28*k], k);

    // vsync mid row block discards the partial block
    pulse_vsync();
    got.delete();
    lv[0] = 16'h1234; lv[1] = 16'h0F00; lv[2] = 16'h0001; lv[3] = 16'h8000;
    do_line(CB, 0, 0);
    pulse_vsync();
    repeat (H) do_line(CB, 0, 0);
    wait_idle(200);
    check("vs_count", got.size(), 28);
    check("vs_row", got[2], 0);
    check("vs_val_lo", got[6], 8'h9C);

    // vsync during a drain leaves it running
    rmode = 1; got.delete();
    repeat (H) do_line(CB, 0, 0);
    repeat (6) tick();
    mif.vsync = 1'b1; repeat (5) tick(); mif.vsync = 1'b0;
    wait_idle(300);
    check("vsd_count", got.size(), 28);

    // Random soak
    do_reset();
    rmode = 3;
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < 6; c++) lv[c] = 16'($urandom);
      do_line($urandom_range(2, 6), $urandom_range(0, 1), 2);
      if ($urandom_range(0, 15) == 0) pulse_vsync();
    end
    rmode = 0;
    wait_idle(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
